// File: rtl/seg_scan_ctrl_57.sv
// seg_scan_ctrl_57: multiplexed seven-segment scan controller.
// Scans DIGITS digits through active-low digit enables and active-high
// segments. Each slot starts with one dead cycle for anti-ghosting. The
// controller also provides PWM brightness, a per-digit blink mask,
// per-digit decimal points and leading-zero suppression.
// All outputs are registered and follow the state and inputs of the
// previous cycle.
module seg_scan_ctrl_57 #(
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250000,
   parameter int IDX_W     = 3
) (
   input  logic                  clk_57,
   input  logic                  rst_57,
   input  logic                  en_57,
   input  logic [4*DIGITS-1:0]   code_57,
   input  logic [DIGITS-1:0]     dp_57,
   input  logic                  blink_e_57,
   input  logic [DIGITS-1:0]     blink_mask_57,
   input  logic                  lz_blank_57,
   input  logic [3:0]            bright_57,
   output logic [6:0]            seg_57,
   output logic                  dp_o_57,
   output logic [DIGITS-1:0]     dig_o_57,
   output logic [IDX_W-1:0]      scan_idx_57
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int BLK_W = $clog2(BLINK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PRE_W-1:0]  r_pre_cnt;
   logic [BLK_W-1:0]  r_blink_cnt;
   logic              r_blink_phase;
   logic [3:0]        r_pwm_cnt;

   logic [DIGITS-1:0] w_zero_above;
   logic              w_run;
   logic [3:0]        w_code;
   logic              w_lit;
   logic              w_hidden;
   logic              w_dark;
   logic              w_supp;
   logic [6:0]        w_seg;
   logic [DIGITS-1:0] w_dig_n;

   // Scan prescaler, digit index, blink timer and PWM counter.
   // The blink timer and the prescaler wrap independently of each other.
   always_ff @(posedge clk_57) begin
      if (rst_57) begin
         r_pre_cnt     <= '0;
         scan_idx_57   <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
         r_pwm_cnt     <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         if (r_pre_cnt == PRE_LAST) begin
            r_pre_cnt   <= '0;
            scan_idx_57 <= (scan_idx_57 == IDX_LAST) ? '0 : scan_idx_57 + 1'b1;
         end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
         end
         if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   // w_zero_above[i] is set when digit i and every digit above it are zero.
   always_comb begin
      w_zero_above = '0;
      w_run        = 1'b1;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         w_run = w_run & (code_57[4*(DIGITS-1-j) +: 4] == 4'h0);
         w_zero_above[DIGITS-1-j] = w_run;
      end
   end

   // Gate the current slot, then decode the selected digit.
   always_comb begin
      w_code   = code_57[4*scan_idx_57 +: 4];
      w_lit    = (bright_57 == 4'hF) | (r_pwm_cnt < bright_57);
      w_hidden = blink_e_57 & blink_mask_57[scan_idx_57] & ~r_blink_phase;
      w_dark   = ~en_57 | (r_pre_cnt == '0) | ~w_lit | w_hidden;
      w_supp   = lz_blank_57 & (scan_idx_57 != '0) & w_zero_above[scan_idx_57];
      case (w_code)
         4'h0:    w_seg = 7'h3F;
         4'h1:    w_seg = 7'h06;
         4'h2:    w_seg = 7'h5B;
         4'h3:    w_seg = 7'h4F;
         4'h4:    w_seg = 7'h66;
         4'h5:    w_seg = 7'h6D;
         4'h6:    w_seg = 7'h7D;
         4'h7:    w_seg = 7'h07;
         4'h8:    w_seg = 7'h7F;
         4'h9:    w_seg = 7'h6F;
         4'hA:    w_seg = 7'h40;
         default: w_seg = 7'h00;
      endcase
      if (w_supp) begin
         w_seg = 7'h00;
      end
      w_dig_n = '1;
      if (!w_dark) begin
         w_dig_n[scan_idx_57] = 1'b0;
      end
   end

   // Output registers. A blanked slot drives no segments and no decimal point.
   always_ff @(posedge clk_57) begin
      if (rst_57) begin
         dig_o_57 <= '1;
         seg_57   <= '0;
         dp_o_57  <= 1'b0;
      end else begin
         dig_o_57 <= w_dig_n;
         seg_57   <= w_dark ? 7'h00 : w_seg;
         dp_o_57  <= w_dark ? 1'b0 : dp_57[scan_idx_57];
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl_57.sv
// tb_seg_scan_ctrl_57: randomized bench for seg_scan_ctrl_57. The reference
// model derives all timing from the number of clocks since reset.
module tb_seg_scan_ctrl_57;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 16;
   localparam int IDX_W     = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [4*DIGITS-1:0] code;
   logic [DIGITS-1:0]   dp;
   logic                blink_e;
   logic [DIGITS-1:0]   mask;
   logic                lz;
   logic [3:0]          bright;
   logic [6:0]          seg;
   logic                dp_o;
   logic [DIGITS-1:0]   dig;
   logic [IDX_W-1:0]    idx_o;

   int n_checks = 0;
   int n_errors = 0;
   int n = 0;

   logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   seg_scan_ctrl_57 #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .BLINK_DIV(BLINK_DIV),
      .IDX_W    (IDX_W)
   ) dut (
      .clk_57       (clk),
      .rst_57       (rst),
      .en_57        (en),
      .code_57      (code),
      .dp_57        (dp),
      .blink_e_57   (blink_e),
      .blink_mask_57(mask),
      .lz_blank_57  (lz),
      .bright_57    (bright),
      .seg_57       (seg),
      .dp_o_57      (dp_o),
      .dig_o_57     (dig),
      .scan_idx_57  (idx_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%h want=%h", tag, n, obs, exp);
      end
   endtask

   // Expected outputs come from the inputs and the clock count since reset.
   task automatic step(input logic do_rst);
      int   pre, idx, pwm;
      bit   vis, lit, hid, dark, supp;
      logic [3:0]        c;
      logic [DIGITS-1:0] e_dig;
      logic [6:0]        e_seg;
      logic              e_dp;
      int                e_idx;
      pre  = n % SCAN_DIV;
      idx  = (n / SCAN_DIV) % DIGITS;
      pwm  = n % 16;
      vis  = ((n / BLINK_DIV) % 2) == 0;
      c    = code[4*idx +: 4];
      lit  = (bright == 4'd15) || (pwm < int'(bright));
      hid  = blink_e && mask[idx] && !vis;
      dark = !en || pre == 0 || !lit || hid;
      supp = lz && idx >= 1 && (code >> (4*idx)) == 0;
      if (dark) begin
         e_dig = '1; e_seg = 7'h00; e_dp = 1'b0;
      end else begin
         e_dig = ~(DIGITS'(1) << idx);
         e_seg = supp ? 7'h00 : LUT[c];
         e_dp  = dp[idx];
      end
      rst = do_rst;
      @(posedge clk);
      if (do_rst) n = 0; else n++;
      @(negedge clk);
      rst = 1'b0;
      if (do_rst) begin
         e_dig = '1; e_seg = 7'h00; e_dp = 1'b0; e_idx = 0;
      end else begin
         e_idx = (n / SCAN_DIV) % DIGITS;
      end
      chk("dig", 32'(dig), 32'(e_dig));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp_o), 32'(e_dp));
      chk("idx", 32'(idx_o), 32'(e_idx));
   endtask

   task automatic rand_inputs();
      int nz;
      nz = $urandom_range(0, DIGITS);
      for (int i = 0; i < DIGITS; i++) begin
         code[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         if (i >= DIGITS - nz) code[4*i +: 4] = 4'h0;
      end
      dp      = DIGITS'($urandom);
      mask    = DIGITS'($urandom);
      blink_e = 1'($urandom);
      lz      = 1'($urandom);
      en      = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
         0:       bright = 4'd15;
         1:       bright = 4'd4;
         2:       bright = 4'd0;
         default: bright = 4'($urandom);
      endcase
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; code = 16'h1234; dp = '0; blink_e = 1'b0;
      mask = '0; lz = 1'b0; bright = 4'd15;
      @(negedge clk);
      step(1'b1);
      // Directed opening: full brightness over several complete scans.
      for (int i = 0; i < 40; i++) step(1'b0);
      code = 16'h00A9; lz = 1'b1; dp = 4'b0100;
      for (int i = 0; i < 32; i++) step(1'b0);
      blink_e = 1'b1; mask = 4'b0011;
      for (int i = 0; i < 20; i++) step(1'b0);
      step(1'b1);
      for (int i = 0; i < 40; i++) step(1'b0);
      // Randomized phase with held inputs, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rand_inputs();
         step($urandom_range(0, 299) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
